// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter. A (pipeline) normally wins over B (multi-cycle unit).
// Define WB_AGING_EN to add B starvation protection (age counter and FORCE_B state).
module regfile_wb_arbiter #(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        force_b
);

  // Handshake: a transfer happens in a cycle where valid && ready; the requester holds
  // valid/addr/data stable until then, and ready is never 1 without the matching valid.
  logic w_grant_a;
  logic w_grant_b;

  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;

`ifdef WB_AGING_EN
  localparam logic [0:0] S_NORMAL  = 1'b0;
  localparam logic [0:0] S_FORCE_B = 1'b1;
  localparam logic [3:0] LIMIT     = 4'(AGE_LIMIT);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_age;
  logic [3:0] w_age_nxt;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst) begin
      if (r_state == S_FORCE_B && b_valid) begin
        w_grant_b = 1'b1;
      end else if (a_valid) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  // Age counts consecutive stalled cycles of B and saturates at the limit.
  always_comb begin
    w_age_nxt = 4'd0;
    if (b_valid && !w_grant_b) begin
      w_age_nxt = (r_age >= LIMIT) ? LIMIT : r_age + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORMAL:  if (w_age_nxt == LIMIT) w_state_nxt = S_FORCE_B;
      S_FORCE_B: if (w_grant_b || !b_valid) w_state_nxt = S_NORMAL;
      default:   w_state_nxt = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NORMAL;
      r_age   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
    end
  end

  assign force_b = (r_state == S_FORCE_B);
`else
  logic w_unused_age_limit;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst) begin
      if (a_valid) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  assign w_unused_age_limit = (AGE_LIMIT != 0);
  assign force_b = 1'b0;
`endif

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  // Writes to register 0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_grant_a && a_addr != 5'd0) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= a_addr;
        r_wr_data <= a_data;
      end else if (w_grant_b && b_addr != 5'd0) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= b_addr;
        r_wr_data <= b_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
